// File: rtl/mem_req_sequencer_if.sv
// ----------------------------------------------------------------------------
// mem_req_sequencer_if
// Groups the three channels that mem_req_sequencer connects to:
//   core request    : req_valid, req_ready, req_rwn, req_addr, req_wdata
//   core response   : rsp_valid, rsp_ready, rsp_rwn, rsp_rdata, rsp_err
//   memunit side    : mem_enable, mem_rwn, mem_addr, mem_data_in (to memunit)
//                     mem_ready, mem_data_out, mem_data_valid (from memunit)
// Modports:
//   slave  - the sequencer's view
//   master - the environment's view (core plus memunit)
// ----------------------------------------------------------------------------
interface mem_req_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rwn;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_rwn;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              mem_enable;
    logic              mem_rwn;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;

    modport slave (
        input  req_valid, req_rwn, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rwn, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_enable, mem_rwn, mem_addr, mem_data_in,
        input  mem_ready, mem_data_out, mem_data_valid
    );

    modport master (
        output req_valid, req_rwn, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rwn, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_enable, mem_rwn, mem_addr, mem_data_in,
        output mem_ready, mem_data_out, mem_data_valid
    );
endinterface

// File: rtl/mem_req_sequencer.sv
// ----------------------------------------------------------------------------
// mem_req_sequencer
// Front-end for memunit. Core load/store requests are buffered in a DEPTH-entry
// FIFO and replayed into memunit's enable/ready handshake one at a time, in
// order. Each request yields exactly one response (read data or write
// completion) on the response channel.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous, active-high reset
//   bus   - mem_req_sequencer_if.slave (request, response and memunit channels)
//   idle  - FIFO empty and FSM in IDLE
//   count - FIFO occupancy (0..DEPTH)
//
// Compile-time option:
//   MEMSEQ_TIMEOUT_EN - when defined, a watchdog counts cycles spent in
//   ISSUE/WAIT; on reaching TIMEOUT the transaction is abandoned and an
//   error response (rsp_err=1, rsp_rdata=0) is returned. When undefined there
//   is no counter and rsp_err is constant 0.
// ----------------------------------------------------------------------------
module mem_req_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_req_sequencer_if.slave     bus,
    output logic                   idle,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;

    logic               head_rwn_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [DATA_W-1:0]  head_wdata_s;

    state_t             state_r;
    state_t             state_nxt_s;

    logic               mem_enable_r;
    logic               mem_enable_nxt_s;
    logic               mem_rwn_r;
    logic               mem_rwn_nxt_s;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [ADDR_W-1:0]  mem_addr_nxt_s;
    logic [DATA_W-1:0]  mem_data_in_r;
    logic [DATA_W-1:0]  mem_data_in_nxt_s;

    logic [DATA_W-1:0]  rdata_cap_r;
    logic [DATA_W-1:0]  rdata_cap_nxt_s;
    logic               capture_s;
    logic [DATA_W-1:0]  cap_val_s;

    logic               rsp_valid_r;
    logic               rsp_valid_nxt_s;
    logic               rsp_rwn_r;
    logic               rsp_rwn_nxt_s;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic [DATA_W-1:0]  rsp_rdata_nxt_s;
    logic               rsp_err_r;
    logic               rsp_err_nxt_s;

    logic               timeout_hit_s;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    assign full_s        = (count_r == CNT_W'(DEPTH));
    assign empty_s       = (count_r == {CNT_W{1'b0}});
    // Ready depends only on the registered count, so a pop in the same cycle
    // as a full FIFO cannot open the door to a push until the next cycle.
    assign bus.req_ready = ~full_s;
    assign push_s        = bus.req_valid & ~full_s;

    assign {head_rwn_s, head_addr_s, head_wdata_s} = fifo_mem_r[rd_ptr_r];

    // FIFO storage: write the incoming request at the write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {bus.req_rwn, bus.req_addr, bus.req_wdata};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef MEMSEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_r;
    logic             busy_s;

    assign busy_s        = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    assign timeout_hit_s = busy_s && (timer_r == TMR_W'(TIMEOUT - 1));

    // Watchdog counter: held at zero in IDLE so every ISSUE entry starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (busy_s && !timeout_hit_s) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end
`else
    logic [31:0] timeout_unused_s;

    assign timeout_unused_s = 32'(TIMEOUT);
    assign timeout_hit_s    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    // Read data is captured only while waiting on a read; the value present
    // in the cycle mem_ready rises still counts.
    assign capture_s = (state_r == ST_WAIT) & bus.mem_data_valid & mem_rwn_r;
    assign cap_val_s = capture_s ? bus.mem_data_out : rdata_cap_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic for the memunit and response channels
    always_comb begin
        state_nxt_s       = state_r;
        pop_s             = 1'b0;
        mem_enable_nxt_s  = mem_enable_r;
        mem_rwn_nxt_s     = mem_rwn_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_data_in_nxt_s = mem_data_in_r;
        rdata_cap_nxt_s   = rdata_cap_r;
        rsp_valid_nxt_s   = rsp_valid_r;
        rsp_rwn_nxt_s     = rsp_rwn_r;
        rsp_rdata_nxt_s   = rsp_rdata_r;
        rsp_err_nxt_s     = rsp_err_r;

        case (state_r)
            ST_IDLE: begin
                if (!empty_s && bus.mem_ready && !rsp_valid_r) begin
                    pop_s             = 1'b1;
                    mem_enable_nxt_s  = 1'b1;
                    mem_rwn_nxt_s     = head_rwn_s;
                    mem_addr_nxt_s    = head_addr_s;
                    mem_data_in_nxt_s = head_wdata_s;
                    rdata_cap_nxt_s   = {DATA_W{1'b0}};
                    state_nxt_s       = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // memunit signals acceptance by dropping ready
                if (!bus.mem_ready) begin
                    mem_enable_nxt_s = 1'b0;
                    state_nxt_s      = ST_WAIT;
                end else if (timeout_hit_s) begin
                    mem_enable_nxt_s = 1'b0;
                    rsp_valid_nxt_s  = 1'b1;
                    rsp_rwn_nxt_s    = mem_rwn_r;
                    rsp_rdata_nxt_s  = {DATA_W{1'b0}};
                    rsp_err_nxt_s    = 1'b1;
                    state_nxt_s      = ST_RESP;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end

            ST_WAIT: begin
                rdata_cap_nxt_s = cap_val_s;
                if (bus.mem_ready) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rwn_nxt_s   = mem_rwn_r;
                    rsp_rdata_nxt_s = cap_val_s;
                    rsp_err_nxt_s   = 1'b0;
                    state_nxt_s     = ST_RESP;
                end else if (timeout_hit_s) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rwn_nxt_s   = mem_rwn_r;
                    rsp_rdata_nxt_s = {DATA_W{1'b0}};
                    rsp_err_nxt_s   = 1'b1;
                    state_nxt_s     = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end

            default: begin
                mem_enable_nxt_s = 1'b0;
                rsp_valid_nxt_s  = 1'b0;
                state_nxt_s      = ST_IDLE;
            end
        endcase
    end

    // Output and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_enable_r  <= 1'b0;
            mem_rwn_r     <= 1'b1;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_data_in_r <= {DATA_W{1'b0}};
            rdata_cap_r   <= {DATA_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rwn_r     <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_err_r     <= 1'b0;
        end else begin
            mem_enable_r  <= mem_enable_nxt_s;
            mem_rwn_r     <= mem_rwn_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_data_in_r <= mem_data_in_nxt_s;
            rdata_cap_r   <= rdata_cap_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_rwn_r     <= rsp_rwn_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            rsp_err_r     <= rsp_err_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_enable  = mem_enable_r;
    assign bus.mem_rwn     = mem_rwn_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_data_in = mem_data_in_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rwn     = rsp_rwn_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;

    assign idle  = empty_s && (state_r == ST_IDLE);
    assign count = count_r;

endmodule

// File: doc/mem_req_sequencer.md
Name: mem_req_sequencer

Overview:
- Upstream front-end for memunit; the CPU core feeds it.
- Accepts load/store requests from the core on a valid/ready interface and buffers them in a small FIFO.
- Replays each request into memunit's enable/ready handshake, strictly one at a time and in order.
- Returns one response per request (read data or write completion) on a valid/ready response channel.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, >= 2
ADDR_W, 16, address width; matches memunit memaddr
DATA_W, 16, data width; matches memunit data_in/data_out
TIMEOUT, 1024, watchdog limit in cycles (used only with MEMSEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  FIFO not full
req_rwn  in  1  1=read, 0=write
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_rwn  out  1  rwn of the completed request
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  timeout flag, qualified by rsp_valid
mem_enable  out  1  to memunit enable
mem_rwn  out  1  to memunit rwn
mem_addr  out  ADDR_W  to memunit memaddr
mem_data_in  out  DATA_W  to memunit data_in
mem_ready  in  1  from memunit ready
mem_data_out  in  DATA_W  from memunit data_out
mem_data_valid  in  1  from memunit data_valid
idle  out  1  FIFO empty and FSM in IDLE
count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst=1): FIFO emptied and count=0; FSM=IDLE; mem_enable=0, mem_rwn=1, mem_addr=0, mem_data_in=0; rsp_valid=0, rsp_rdata=0, rsp_rwn=0, rsp_err=0; idle=1. This block does not reset memunit.
- Reset mid-transaction: mem_enable drops immediately (async); no response is produced for the in-flight request.
- req_ready = !full, combinational from count. Push occurs when req_valid && req_ready.
- When full, a same-cycle pop does not enable a push; the push waits one cycle.
- Push and pop in the same cycle leave count unchanged. Read/write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty && mem_ready==1 && rsp_valid==0, pop the head. Latch rwn/addr/wdata onto mem_* outputs, clear the rdata capture register to 0, go to ISSUE. Otherwise stay.
  - ISSUE: mem_enable=1; mem_* outputs held stable. When mem_ready==0 (accepted), mem_enable=0 on the next edge, go to WAIT.
  - WAIT: mem_enable=0. A cycle with mem_data_valid==1 and mem_rwn==1 captures mem_data_out; the last capture wins. When mem_ready==1, go to RESP. A data_valid in that same cycle is still captured.
  - RESP: rsp_valid=1. rsp_rwn = latched rwn. rsp_rdata = capture register (0 for writes). Outputs stable until rsp_ready==1; then rsp_valid=0 on the next edge and go to IDLE.
- rsp_valid and rsp_ready high together in RESP: the response is consumed and the next issue may start on the following cycle (IDLE).
- Read with no data_valid seen: rsp_rdata=0, rsp_err=0 (no watchdog); it is the core's problem.
- Minimum request-to-response latency: 1 cycle (push) + IDLE + ISSUE + memunit ready-fall + memunit ready-rise + 1 (RESP).
- Ordering: strictly FIFO; at most one memunit transaction outstanding.
- idle = (count==0) && state==IDLE, registered-state based.

Optional Feature:
MEMSEQ_TIMEOUT_EN
- Defined:
  - A cycle counter runs in ISSUE and WAIT and is cleared on entry to ISSUE.
  - When it reaches TIMEOUT: mem_enable=0, go to RESP with rsp_err=1 and rsp_rdata=0.
  - An error response is consumed like a normal response.
- Not defined:
  - No counter.
  - rsp_err tied to 0.
  - The FSM waits in ISSUE/WAIT indefinitely.

Test Plan:
- Write then read back: push write addr 0x0000 data 15, then read addr 0x0000, with the SDRAM model attached -> response 1: rsp_rwn=0, rdata=0; response 2: rsp_rwn=1, rdata=15; mem_enable pulses exactly twice.
- FIFO fill: hold memunit mem_ready=0 and push DEPTH=4 requests -> req_ready=0 after the 4th, count=4. The 5th push is refused until the first completes.
- Backpressure: hold rsp_ready=0 after the first read (addr 0x0010, data 0xBEEF) -> rsp_valid and rsp_rdata=0xBEEF stable. No second mem_enable until rsp_ready=1.
- Ordering: writes A5A5@1, 5A5A@2, then reads @2 and @1 -> read responses 0x5A5A then 0xA5A5.
- Reset mid-WAIT: assert rst while mem_enable=0 and ready low -> mem_enable=0, count=0, rsp_valid=0 immediately; idle=1 after release.
- With MEMSEQ_TIMEOUT_EN, TIMEOUT=16: stub memunit that never raises mem_ready after acceptance -> rsp_valid with rsp_err=1, rsp_rdata=0 about 16 cycles after ISSUE entry.
